// File: rtl/data_from_l2_pkg.sv
// Shared sizing helpers for the L2 fill datapath: beat count, index widths.
package data_from_l2_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int beats(input int bus, input int line);
        return line / bus;
    endfunction

    // Never returns 0 so that index/pointer vectors stay legal at size 1.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    localparam int DEF_BEATS = beats(64, 128);
    localparam int DEF_IDX_W = idx_w(DEF_BEATS);
    typedef logic [DEF_IDX_W-1:0] beat_idx_t;

endpackage

// File: rtl/data_from_l2_line_assembler_if.sv
// L2 beat bus in, assembled-line bus out; slave is the assembler's view.
interface data_from_l2_line_assembler_if
    import data_from_l2_pkg::*;
#(
    parameter int L2_BUS_WIDTH = 64,
    parameter int BUFFER_WIDTH = 128,
    parameter int DEPTH        = 2
);
    localparam int BEATS = beats(L2_BUS_WIDTH, BUFFER_WIDTH);
    localparam int IW    = idx_w(BEATS);
    localparam int CW    = clog2(DEPTH) + 1;

    logic                    DATA_FROM_L2_VALID;
    logic                    DATA_FROM_L2_READY;
    logic [L2_BUS_WIDTH-1:0] DATA_FROM_L2;
    logic [IW-1:0]           DATA_FROM_L2_WORD_IDX;
    logic                    DATA_FROM_L2_BUFFER_VALID;
    logic                    DATA_FROM_L2_BUFFER_READY;
    logic [BUFFER_WIDTH-1:0] DATA_FROM_L2_BUFFER;
    logic [IW-1:0]           DATA_FROM_L2_BUFFER_CWF_IDX;
    logic [BEATS-1:0]        DATA_FROM_L2_BUFFER_ENB;
    logic [CW-1:0]           DATA_FROM_L2_BUFFER_COUNT;

    modport master (
        output DATA_FROM_L2_VALID, DATA_FROM_L2, DATA_FROM_L2_WORD_IDX, DATA_FROM_L2_BUFFER_READY,
        input  DATA_FROM_L2_READY, DATA_FROM_L2_BUFFER_VALID, DATA_FROM_L2_BUFFER,
               DATA_FROM_L2_BUFFER_CWF_IDX, DATA_FROM_L2_BUFFER_ENB, DATA_FROM_L2_BUFFER_COUNT
    );

    modport slave (
        input  DATA_FROM_L2_VALID, DATA_FROM_L2, DATA_FROM_L2_WORD_IDX, DATA_FROM_L2_BUFFER_READY,
        output DATA_FROM_L2_READY, DATA_FROM_L2_BUFFER_VALID, DATA_FROM_L2_BUFFER,
               DATA_FROM_L2_BUFFER_CWF_IDX, DATA_FROM_L2_BUFFER_ENB, DATA_FROM_L2_BUFFER_COUNT
    );
endinterface

// File: rtl/data_from_l2_line_fifo.sv
// First-word-fall-through FIFO of completed lines; head data read straight from storage.
module data_from_l2_line_fifo
    import data_from_l2_pkg::*;
#(
    parameter int WIDTH = 129,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);
    localparam int PW = idx_w(DEPTH);
    localparam int CW = clog2(DEPTH) + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;

    // Explicit wrap keeps DEPTH=1 (1-bit pointer, single slot) pinned at 0.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = nxt(wr_ptr_q);
        end
        if (pop) rd_ptr_d = nxt(rd_ptr_q);
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/data_from_l2_line_assembler.sv
// Packs narrow L2 beats (critical-word-first order) into cache lines and queues them for L1.
module data_from_l2_line_assembler
    import data_from_l2_pkg::*;
#(
    parameter int L2_BUS_WIDTH = 64,
    parameter int BUFFER_WIDTH = 128,
    parameter int DEPTH        = 2,
    parameter int CWF_EN       = 1
) (
    input logic CLK,
    input logic RST,
    input logic ENB,
    data_from_l2_line_assembler_if.slave bus
);
    localparam int BEATS = beats(L2_BUS_WIDTH, BUFFER_WIDTH);
    localparam int IW    = idx_w(BEATS);
    localparam int CW    = clog2(DEPTH) + 1;

    logic [IW-1:0]                         cnt_q, cnt_d, base_q, base_d, idx, first_idx;
    logic [BEATS-1:0][L2_BUS_WIDTH-1:0]    asm_q, asm_d, line_merged;
    logic [BEATS-1:0]                      enb;
    logic                                  last, acc, push, pop, full, empty, ready;
    logic [CW-1:0]                         count;
    logic [IW+BUFFER_WIDTH-1:0]            head;

    always_comb begin
        last      = (cnt_q == IW'(BEATS - 1));
        pop       = bus.DATA_FROM_L2_BUFFER_READY & ~empty & ENB;
        // Only the closing beat of a line needs a free FIFO slot.
        ready     = ENB & ~RST & (~last | ~full | pop);
        acc       = bus.DATA_FROM_L2_VALID & ready;
        push      = acc & last;
        first_idx = (CWF_EN != 0) ? bus.DATA_FROM_L2_WORD_IDX : '0;
        idx       = (cnt_q == '0) ? first_idx : IW'(base_q + cnt_q);

        cnt_d            = cnt_q;
        base_d           = base_q;
        asm_d            = asm_q;
        enb              = '0;
        line_merged      = asm_q;
        line_merged[idx] = bus.DATA_FROM_L2;
        if (acc) begin
            asm_d[idx] = bus.DATA_FROM_L2;
            enb[idx]   = 1'b1;
            cnt_d      = last ? '0 : cnt_q + 1'b1;
            if (cnt_q == '0) base_d = idx;
        end
    end

    // Assembly register is left unreset; a zeroed counter discards any partial line.
    always_ff @(posedge CLK) begin
        asm_q <= asm_d;
        if (RST) begin
            cnt_q  <= '0;
            base_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            base_q <= base_d;
        end
    end

    data_from_l2_line_fifo #(
        .WIDTH(IW + BUFFER_WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (CLK),
        .rst  (RST),
        .push (push),
        .pop  (pop),
        .wdata({base_q, line_merged}),
        .rdata(head),
        .full (full),
        .empty(empty),
        .count(count)
    );

    assign bus.DATA_FROM_L2_READY          = ready;
    assign bus.DATA_FROM_L2_BUFFER_VALID   = ~empty;
    assign bus.DATA_FROM_L2_BUFFER         = head[BUFFER_WIDTH-1:0];
    assign bus.DATA_FROM_L2_BUFFER_CWF_IDX = head[IW+BUFFER_WIDTH-1:BUFFER_WIDTH];
    assign bus.DATA_FROM_L2_BUFFER_ENB     = enb;
    assign bus.DATA_FROM_L2_BUFFER_COUNT   = count;
endmodule

// File: tb/tb_data_from_l2_line_assembler.sv
// Bench: 2-beat instance for vector table and corner sequences, 4-beat instance for CWF and soak.
module tb_data_from_l2_line_assembler;
    logic clk = 1'b0;
    logic rst2, enb2, rst4, enb4;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    data_from_l2_line_assembler_if #(.L2_BUS_WIDTH(64), .BUFFER_WIDTH(128), .DEPTH(2)) if2 ();
    data_from_l2_line_assembler_if #(.L2_BUS_WIDTH(64), .BUFFER_WIDTH(256), .DEPTH(2)) if4 ();

    data_from_l2_line_assembler #(.L2_BUS_WIDTH(64), .BUFFER_WIDTH(128), .DEPTH(2), .CWF_EN(1))
        dut2 (.CLK(clk), .RST(rst2), .ENB(enb2), .bus(if2));
    data_from_l2_line_assembler #(.L2_BUS_WIDTH(64), .BUFFER_WIDTH(256), .DEPTH(2), .CWF_EN(1))
        dut4 (.CLK(clk), .RST(rst4), .ENB(enb4), .bus(if4));

    typedef struct packed {
        logic        v;
        logic [63:0] d;
        logic        w;
        logic        br;
        logic        e_rdy;
        logic [1:0]  e_enb;
        logic        e_bv;
        logic [1:0]  e_cnt;
        logic        cb;
        logic [127:0] e_buf;
        logic        e_cwf;
    } vec_t;

    localparam logic [63:0] A = 64'hAAAA_0000_0000_000A, B = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] C = 64'hCCCC_0000_0000_000C, D = 64'hDDDD_0000_0000_000D;
    localparam logic [63:0] E = 64'hEEEE_0000_0000_000E, F = 64'hFFFF_0000_0000_000F;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input logic v, input logic [63:0] d, input logic w, input logic br);
        if2.DATA_FROM_L2_VALID        = v;
        if2.DATA_FROM_L2              = d;
        if2.DATA_FROM_L2_WORD_IDX     = w;
        if2.DATA_FROM_L2_BUFFER_READY = br;
        #1;
    endtask

    task automatic cyc4(input logic v, input logic [63:0] d, input logic [1:0] w, input logic br);
        if4.DATA_FROM_L2_VALID        = v;
        if4.DATA_FROM_L2              = d;
        if4.DATA_FROM_L2_WORD_IDX     = w;
        if4.DATA_FROM_L2_BUFFER_READY = br;
        #1;
    endtask

    task automatic reset2;
        enb2 = 1'b1;
        rst2 = 1'b1;
        cyc2(1'b1, A, 1'b0, 1'b1);
        adv;
        cyc2(1'b1, A, 1'b0, 1'b1);
        chk("rst_ready", 256'(if2.DATA_FROM_L2_READY), 256'(0));
        chk("rst_enb", 256'(if2.DATA_FROM_L2_BUFFER_ENB), 256'(0));
        chk("rst_valid", 256'(if2.DATA_FROM_L2_BUFFER_VALID), 256'(0));
        chk("rst_count", 256'(if2.DATA_FROM_L2_BUFFER_COUNT), 256'(0));
        adv;
        rst2 = 1'b0;
    endtask

    task automatic reset4;
        enb4 = 1'b1;
        rst4 = 1'b1;
        cyc4(1'b0, '0, 2'd0, 1'b0);
        adv;
        adv;
        rst4 = 1'b0;
    endtask

    vec_t        tv[12];
    logic [63:0] ld[3][2];
    logic [63:0] x0, x1, n0, n1;
    logic [63:0] dd[4];

    // Soak reference: lines kept as whole vectors, slot = (first index + beat number) mod 4.
    logic [255:0] qline[$];
    int           qidx[$];
    logic [255:0] cur_line;
    int           n_beat, base, lines_out;

    initial begin
        rst2 = 1'b1; enb2 = 1'b0; rst4 = 1'b1; enb4 = 1'b0;
        cyc2(1'b0, '0, 1'b0, 1'b0);
        cyc4(1'b0, '0, 2'd0, 1'b0);

        // ---- Vector table: back-to-back lines, CWF wrap, push while holding, pops
        tv[0]  = '{1'b1, A,     1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'd0, 1'b0, 128'd0,  1'b0};
        tv[1]  = '{1'b1, B,     1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 128'd0,  1'b0};
        tv[2]  = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 2'd1, 1'b1, {B, A}, 1'b0};
        tv[3]  = '{1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 128'd0,  1'b0};
        tv[4]  = '{1'b1, C,     1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 128'd0,  1'b0};
        tv[5]  = '{1'b1, D,     1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'd0, 1'b0, 128'd0,  1'b0};
        tv[6]  = '{1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'd1, 1'b1, {C, D}, 1'b1};
        tv[7]  = '{1'b1, E,     1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'd1, 1'b1, {C, D}, 1'b1};
        tv[8]  = '{1'b1, F,     1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'd1, 1'b0, 128'd0,  1'b0};
        tv[9]  = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 2'd2, 1'b1, {C, D}, 1'b1};
        tv[10] = '{1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 2'd1, 1'b1, {F, E}, 1'b0};
        tv[11] = '{1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 128'd0,  1'b0};

        adv;
        reset2;
        for (int i = 0; i < 12; i++) begin
            cyc2(tv[i].v, tv[i].d, tv[i].w, tv[i].br);
            chk($sformatf("t1_ready[%0d]", i), 256'(if2.DATA_FROM_L2_READY), 256'(tv[i].e_rdy));
            chk($sformatf("t1_enb[%0d]", i), 256'(if2.DATA_FROM_L2_BUFFER_ENB), 256'(tv[i].e_enb));
            chk($sformatf("t1_valid[%0d]", i), 256'(if2.DATA_FROM_L2_BUFFER_VALID), 256'(tv[i].e_bv));
            chk($sformatf("t1_count[%0d]", i), 256'(if2.DATA_FROM_L2_BUFFER_COUNT), 256'(tv[i].e_cnt));
            if (tv[i].cb) begin
                chk($sformatf("t1_line[%0d]", i), 256'(if2.DATA_FROM_L2_BUFFER), 256'(tv[i].e_buf));
                chk($sformatf("t1_cwf[%0d]", i), 256'(if2.DATA_FROM_L2_BUFFER_CWF_IDX), 256'(tv[i].e_cwf));
            end
            adv;
        end

        // ---- BEATS=4, first beat at slice 2
        reset4;
        for (int i = 0; i < 4; i++) dd[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            cyc4(1'b1, dd[i], (i == 0) ? 2'd2 : 2'd0, 1'b0);
            chk($sformatf("t2_enb[%0d]", i), 256'(if4.DATA_FROM_L2_BUFFER_ENB),
                256'(4'b0001 << ((2 + i) % 4)));
            adv;
        end
        cyc4(1'b0, '0, 2'd0, 1'b0);
        chk("t2_valid", 256'(if4.DATA_FROM_L2_BUFFER_VALID), 256'(1));
        chk("t2_line", if4.DATA_FROM_L2_BUFFER, {dd[1], dd[0], dd[3], dd[2]});
        chk("t2_cwf", 256'(if4.DATA_FROM_L2_BUFFER_CWF_IDX), 256'(2));
        adv;

        // ---- Backpressure: 3 lines, sink stalled, last beat of line 3 waits for a pop
        reset2;
        for (int l = 0; l < 3; l++) for (int b = 0; b < 2; b++) ld[l][b] = {$urandom, $urandom};
        for (int l = 0; l < 2; l++) for (int b = 0; b < 2; b++) begin
            cyc2(1'b1, ld[l][b], 1'b0, 1'b0);
            adv;
        end
        cyc2(1'b1, ld[2][0], 1'b0, 1'b0);
        chk("t3_count_full", 256'(if2.DATA_FROM_L2_BUFFER_COUNT), 256'(2));
        chk("t3_first_beat_ready", 256'(if2.DATA_FROM_L2_READY), 256'(1));
        adv;
        cyc2(1'b1, ld[2][1], 1'b0, 1'b0);
        chk("t3_stall", 256'(if2.DATA_FROM_L2_READY), 256'(0));
        chk("t3_stall_enb", 256'(if2.DATA_FROM_L2_BUFFER_ENB), 256'(0));
        adv;
        cyc2(1'b1, ld[2][1], 1'b0, 1'b0);
        chk("t3_stall2", 256'(if2.DATA_FROM_L2_READY), 256'(0));
        adv;
        cyc2(1'b1, ld[2][1], 1'b0, 1'b1);
        chk("t3_pop_accept", 256'(if2.DATA_FROM_L2_READY), 256'(1));
        chk("t3_pop_enb", 256'(if2.DATA_FROM_L2_BUFFER_ENB), 256'(2'b10));
        chk("t3_head1", 256'(if2.DATA_FROM_L2_BUFFER), 256'({ld[0][1], ld[0][0]}));
        adv;
        cyc2(1'b0, '0, 1'b0, 1'b0);
        chk("t3_count_held", 256'(if2.DATA_FROM_L2_BUFFER_COUNT), 256'(2));
        chk("t3_head2", 256'(if2.DATA_FROM_L2_BUFFER), 256'({ld[1][1], ld[1][0]}));
        adv;
        cyc2(1'b0, '0, 1'b0, 1'b1);
        adv;
        cyc2(1'b0, '0, 1'b0, 1'b1);
        chk("t3_head3", 256'(if2.DATA_FROM_L2_BUFFER), 256'({ld[2][1], ld[2][0]}));
        chk("t3_count1", 256'(if2.DATA_FROM_L2_BUFFER_COUNT), 256'(1));
        adv;
        cyc2(1'b0, '0, 1'b0, 1'b0);
        chk("t3_drained", 256'(if2.DATA_FROM_L2_BUFFER_VALID), 256'(0));
        adv;

        // ---- ENB=0 mid-line with L2 valid held
        reset2;
        x0 = {$urandom, $urandom};
        x1 = {$urandom, $urandom};
        cyc2(1'b1, x0, 1'b1, 1'b0);
        adv;
        enb2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc2(1'b1, x1, 1'b0, 1'b0);
            chk($sformatf("t4_ready_off[%0d]", i), 256'(if2.DATA_FROM_L2_READY), 256'(0));
            chk($sformatf("t4_enb_off[%0d]", i), 256'(if2.DATA_FROM_L2_BUFFER_ENB), 256'(0));
            adv;
        end
        enb2 = 1'b1;
        cyc2(1'b1, x1, 1'b0, 1'b0);
        chk("t4_resume_ready", 256'(if2.DATA_FROM_L2_READY), 256'(1));
        chk("t4_resume_enb", 256'(if2.DATA_FROM_L2_BUFFER_ENB), 256'(2'b01));
        adv;
        enb2 = 1'b0;
        cyc2(1'b0, '0, 1'b0, 1'b1);
        chk("t4_valid_ungated", 256'(if2.DATA_FROM_L2_BUFFER_VALID), 256'(1));
        adv;
        cyc2(1'b0, '0, 1'b0, 1'b1);
        chk("t4_no_pop", 256'(if2.DATA_FROM_L2_BUFFER_COUNT), 256'(1));
        chk("t4_line", 256'(if2.DATA_FROM_L2_BUFFER), 256'({x0, x1}));
        chk("t4_cwf", 256'(if2.DATA_FROM_L2_BUFFER_CWF_IDX), 256'(1));
        adv;
        enb2 = 1'b1;

        // ---- Reset with COUNT=2 and a partial line
        reset2;
        for (int l = 0; l < 2; l++) for (int b = 0; b < 2; b++) begin
            cyc2(1'b1, ld[l][b], 1'b0, 1'b0);
            adv;
        end
        cyc2(1'b1, ld[2][0], 1'b1, 1'b0);
        adv;
        rst2 = 1'b1;
        cyc2(1'b1, ld[2][1], 1'b0, 1'b0);
        chk("t5_rst_ready", 256'(if2.DATA_FROM_L2_READY), 256'(0));
        adv;
        rst2 = 1'b0;
        n0 = {$urandom, $urandom};
        n1 = {$urandom, $urandom};
        cyc2(1'b1, n0, 1'b0, 1'b0);
        chk("t5_count", 256'(if2.DATA_FROM_L2_BUFFER_COUNT), 256'(0));
        chk("t5_valid", 256'(if2.DATA_FROM_L2_BUFFER_VALID), 256'(0));
        chk("t5_fresh_enb", 256'(if2.DATA_FROM_L2_BUFFER_ENB), 256'(2'b01));
        adv;
        cyc2(1'b1, n1, 1'b1, 1'b0);
        chk("t5_second_enb", 256'(if2.DATA_FROM_L2_BUFFER_ENB), 256'(2'b10));
        adv;
        cyc2(1'b0, '0, 1'b0, 1'b0);
        chk("t5_line", 256'(if2.DATA_FROM_L2_BUFFER), 256'({n1, n0}));
        chk("t5_cwf", 256'(if2.DATA_FROM_L2_BUFFER_CWF_IDX), 256'(0));
        chk("t5_count1", 256'(if2.DATA_FROM_L2_BUFFER_COUNT), 256'(1));
        adv;

        // ---- Random soak on the 4-beat instance against a line scoreboard
        reset4;
        n_beat = 0; base = 0; lines_out = 0; cur_line = '0;
        for (int c = 0; c < 10000; c++) begin
            logic        v, br, e, acc, pop_exp, rdy_exp;
            logic [63:0] d;
            int          w, slot;
            v  = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 2) != 0);
            e  = ($urandom_range(0, 9) != 0);
            w  = $urandom_range(0, 3);
            d  = {$urandom, $urandom};
            enb4 = e;
            cyc4(v, d, 2'(w), br);
            pop_exp = br && e && (qline.size() > 0);
            rdy_exp = e && ((n_beat != 3) || (qline.size() < 2) || pop_exp);
            chk("soak_valid", 256'(if4.DATA_FROM_L2_BUFFER_VALID), 256'(qline.size() > 0));
            chk("soak_count", 256'(if4.DATA_FROM_L2_BUFFER_COUNT), 256'(qline.size()));
            chk("soak_ready", 256'(if4.DATA_FROM_L2_READY), 256'(rdy_exp));
            acc  = v && if4.DATA_FROM_L2_READY;
            slot = (n_beat == 0) ? w : (base + n_beat) % 4;
            chk("soak_enb", 256'(if4.DATA_FROM_L2_BUFFER_ENB), acc ? (256'(1) << slot) : 256'(0));
            if (pop_exp) begin
                chk("soak_line", if4.DATA_FROM_L2_BUFFER, qline[0]);
                chk("soak_cwf", 256'(if4.DATA_FROM_L2_BUFFER_CWF_IDX), 256'(qidx[0]));
                void'(qline.pop_front());
                void'(qidx.pop_front());
                lines_out++;
            end
            if (acc) begin
                if (n_beat == 0) base = w;
                cur_line[slot*64 +: 64] = d;
                n_beat++;
                if (n_beat == 4) begin
                    qline.push_back(cur_line);
                    qidx.push_back(base);
                    n_beat = 0;
                end
            end
            adv;
        end
        chk("soak_progress", 256'(lines_out > 500), 256'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
